// File: rtl/luma_win_pkg.sv
// Shared types, window latency and tap indexing for the 3x3 luma window block.
package luma_win_pkg;

  localparam int PKG_DW  = 8;
  localparam int WIN_LAT = 2;

  typedef logic [PKG_DW-1:0] pix_t;
  typedef pix_t [2:0][2:0]   win_t;

  // Flat tap position within win_o: row-major, r=2 is the current line.
  function automatic int tap_idx(input int r, input int c);
    return r * 3 + c;
  endfunction

endpackage

// File: rtl/lum_line_ram.sv
// Simple dual-port line buffer with a registered read port, mapped onto block RAM.
module lum_line_ram
  import luma_win_pkg::*;
#(
  parameter int DEPTH = 1920,
  parameter int DW    = 8,
  parameter int AW    = 11
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:DEPTH-1];

  // Contents are deliberately left unreset so the array maps onto a RAM primitive.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/luma_win3x3.sv
// Sliding 3x3 luma window built from two line buffers and per-row column shifters.
// Build option: define LUMA_WIN_REPLICATE_EN for border replication from pixel (0,0).
module luma_win3x3
  import luma_win_pkg::*;
#(
  parameter int MAX_WIDTH = 1920,
  parameter int DW        = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] y_i,
  input  logic          dv_i,
  input  logic          hs_i,
  input  logic          vs_i,
  input  logic          line_end_i,
  output logic [9*DW-1:0] win_o,
  output logic          win_valid_o,
  output logic          dv_o,
  output logic          hs_o,
  output logic          vs_o,
  output logic          line_end_o
);

  localparam int AW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
  localparam int CW = $clog2(MAX_WIDTH + 1);

`ifdef LUMA_WIN_REPLICATE_EN
  localparam bit REPLICATE = 1'b1;
`else
  localparam bit REPLICATE = 1'b0;
`endif

  logic [CW-1:0] col_cnt_reg, col_cnt_next;
  logic [1:0]    row_cnt_reg, row_cnt_next;
  logic          vs_prev_reg;
  logic          vs_rise;
  logic          in_range;

  logic          v_d1_reg;
  logic [DW-1:0] y_d1_reg;
  logic [AW-1:0] col_d1_reg;
  logic [1:0]    row_d1_reg;

  logic [DW-1:0] lb0_rdata;
  logic [DW-1:0] lb1_rdata;
  logic [DW-1:0] row_new [3];

  logic          load_all;
  logic          win_valid_reg, win_valid_next;
  logic [3:0]    sync_reg [WIN_LAT];

  assign vs_rise  = vs_i & ~vs_prev_reg;
  assign in_range = dv_i && (col_cnt_reg < CW'(MAX_WIDTH));

  // A pixel coinciding with line_end is counted, then the clear wins.
  always_comb begin
    col_cnt_next = col_cnt_reg;
    if (in_range) begin
      col_cnt_next = col_cnt_reg + CW'(1);
    end
    if (line_end_i || vs_rise) begin
      col_cnt_next = '0;
    end
  end

  always_comb begin
    row_cnt_next = row_cnt_reg;
    if (vs_rise) begin
      row_cnt_next = 2'd0;
    end else if (line_end_i && (row_cnt_reg != 2'd2)) begin
      row_cnt_next = row_cnt_reg + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_cnt_reg <= '0;
      row_cnt_reg <= 2'd0;
      vs_prev_reg <= 1'b0;
      v_d1_reg    <= 1'b0;
      y_d1_reg    <= '0;
      col_d1_reg  <= '0;
      row_d1_reg  <= 2'd0;
    end else begin
      col_cnt_reg <= col_cnt_next;
      row_cnt_reg <= row_cnt_next;
      vs_prev_reg <= vs_i;
      v_d1_reg    <= in_range;
      y_d1_reg    <= y_i;
      col_d1_reg  <= col_cnt_reg[AW-1:0];
      row_d1_reg  <= row_cnt_reg;
    end
  end

  // lb0 holds the previous line; lb1 receives what lb0 held, one line older.
  lum_line_ram #(.DEPTH(MAX_WIDTH), .DW(DW), .AW(AW)) u_lb0 (
    .clk   (clk),
    .we    (v_d1_reg),
    .waddr (col_d1_reg),
    .wdata (y_d1_reg),
    .re    (in_range),
    .raddr (col_cnt_reg[AW-1:0]),
    .rdata (lb0_rdata)
  );

  lum_line_ram #(.DEPTH(MAX_WIDTH), .DW(DW), .AW(AW)) u_lb1 (
    .clk   (clk),
    .we    (v_d1_reg),
    .waddr (col_d1_reg),
    .wdata (lb0_rdata),
    .re    (in_range),
    .raddr (col_cnt_reg[AW-1:0]),
    .rdata (lb1_rdata)
  );

  always_comb begin
    row_new[2] = y_d1_reg;
    row_new[1] = lb0_rdata;
    row_new[0] = lb1_rdata;
`ifdef LUMA_WIN_REPLICATE_EN
    // Missing rows above the frame borrow the nearest line that exists.
    if (row_d1_reg == 2'd0) begin
      row_new[1] = y_d1_reg;
      row_new[0] = y_d1_reg;
    end else if (row_d1_reg == 2'd1) begin
      row_new[0] = lb0_rdata;
    end
`endif
  end

  assign load_all = REPLICATE && (col_d1_reg == '0);

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_row
      localparam int K0 = tap_idx(gi, 0);
      localparam int K1 = tap_idx(gi, 1);
      localparam int K2 = tap_idx(gi, 2);
      logic [DW-1:0] c0_reg, c1_reg, c2_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          c0_reg <= '0;
          c1_reg <= '0;
          c2_reg <= '0;
        end else if (v_d1_reg) begin
          c0_reg <= load_all ? row_new[gi] : c1_reg;
          c1_reg <= load_all ? row_new[gi] : c2_reg;
          c2_reg <= row_new[gi];
        end
      end

      assign win_o[K0*DW +: DW] = c0_reg;
      assign win_o[K1*DW +: DW] = c1_reg;
      assign win_o[K2*DW +: DW] = c2_reg;
    end
  endgenerate

  assign win_valid_next = v_d1_reg &&
                          (REPLICATE || ((row_d1_reg == 2'd2) && (32'(col_d1_reg) >= 32'd2)));

  always_ff @(posedge clk) begin
    if (rst) begin
      win_valid_reg <= 1'b0;
      for (int i = 0; i < WIN_LAT; i++) begin
        sync_reg[i] <= 4'd0;
      end
    end else begin
      win_valid_reg <= win_valid_next;
      sync_reg[0]   <= {dv_i, hs_i, vs_i, line_end_i};
      for (int i = 1; i < WIN_LAT; i++) begin
        sync_reg[i] <= sync_reg[i-1];
      end
    end
  end

  assign win_valid_o = win_valid_reg;
  assign dv_o        = sync_reg[WIN_LAT-1][3];
  assign hs_o        = sync_reg[WIN_LAT-1][2];
  assign vs_o        = sync_reg[WIN_LAT-1][1];
  assign line_end_o  = sync_reg[WIN_LAT-1][0];

endmodule
